// File: rtl/scan_doubler_pkg.sv
// Shared constants, types and helpers for the scan_doubler_px line doubler.
package scan_doubler_pkg;

  // Default geometry; the top module can override these through its parameters.
  localparam int CH_W    = 3;
  localparam int NCH     = 3;
  localparam int RGB_W   = CH_W * NCH;
  localparam int MAX_PIX = 512;
  localparam int ADDR_W  = $clog2(MAX_PIX);
  localparam int LPER_W  = 11;
  localparam int HSYNC_W = 48;
  localparam int H_START = 40;

  // Output sync/blank bundle carried down the two-stage output pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic line_sel;
  } sync_t;

  // Reset values of the output side.
  localparam logic             RST_HSYNC    = 1'b0;
  localparam logic             RST_VSYNC    = 1'b0;
  localparam logic             RST_BLANK    = 1'b1;
  localparam logic             RST_LINE_SEL = 1'b0;
  localparam logic [RGB_W-1:0] RST_RGB      = '0;
  localparam sync_t            SYNC_RST     = '{hsync:    RST_HSYNC,
                                                vsync:    RST_VSYNC,
                                                blank:    RST_BLANK,
                                                line_sel: RST_LINE_SEL};

  // Halve every colour channel independently (no carry between channels).
  function automatic logic [RGB_W-1:0] half_intensity(input logic [RGB_W-1:0] rgb);
    logic [RGB_W-1:0] res;
    res = '0;
    for (int c = 0; c < NCH; c++) begin
      res[c*CH_W +: CH_W] = rgb[c*CH_W +: CH_W] >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_doubler_px_if.sv
// Video bus between the game core, the line doubler and the output stage.
// master = video source side, slave = scan_doubler_px.
interface scan_doubler_px_if #(
  parameter int RGB_W = scan_doubler_pkg::RGB_W
);
  logic             pix_ce_i;
  logic             hsync_i;
  logic             vsync_i;
  logic             hblank_i;
  logic             vblank_i;
  logic [RGB_W-1:0] rgb_i;
  logic             hsync_o;
  logic             vsync_o;
  logic             blank_o;
  logic [RGB_W-1:0] rgb_o;
  logic             line_sel_o;

  modport master (
    output pix_ce_i, hsync_i, vsync_i, hblank_i, vblank_i, rgb_i,
    input  hsync_o, vsync_o, blank_o, rgb_o, line_sel_o
  );

  modport slave (
    input  pix_ce_i, hsync_i, vsync_i, hblank_i, vblank_i, rgb_i,
    output hsync_o, vsync_o, blank_o, rgb_o, line_sel_o
  );
endinterface

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The bank bit is the address MSB; contents are never reset.
module line_buffer_dp #(
  parameter int DW = 9,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port (one clock of latency).
  always_ff @(posedge clk) begin
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/scan_doubler_px.sv
// scan_doubler_px: captures one input video line on pix_ce into a ping-pong
// line buffer and replays the previous line twice at the full clock rate.
// Optional macro SCANLINE_EN: the second replay of each line is dimmed to
// half intensity per colour channel.
module scan_doubler_px #(
  parameter int CH_W    = scan_doubler_pkg::CH_W,
  parameter int NCH     = scan_doubler_pkg::NCH,
  parameter int MAX_PIX = scan_doubler_pkg::MAX_PIX,
  parameter int LPER_W  = scan_doubler_pkg::LPER_W,
  parameter int HSYNC_W = scan_doubler_pkg::HSYNC_W,
  parameter int H_START = scan_doubler_pkg::H_START
) (
  input  logic              clk,
  input  logic              reset_n,
  scan_doubler_px_if.slave  vid
);
  import scan_doubler_pkg::*;

  localparam int                PIX_W     = CH_W * NCH;
  localparam int                AW        = $clog2(MAX_PIX);
  localparam logic [LPER_W-1:0] LPER_SAT  = '1;
  localparam logic [AW:0]       WCNT_FULL = (AW+1)'(MAX_PIX);

  // Input side state
  logic              hs_prev_reg;
  logic              wsel_reg;
  logic [AW:0]       wcnt_reg;
  logic [LPER_W-1:0] lcnt_reg;
  logic [LPER_W-1:0] half_reg;
  logic [AW:0]       rlen_reg;
  logic              vs_line_reg;
  logic              vb_line_reg;
  logic              seen_reg;
  logic              valid_reg;

  // Output timing state
  logic [LPER_W-1:0] out_cnt_reg;
  logic              line_sel_reg;
  logic              overrun_reg;

  // Output pipeline
  sync_t             st1_reg;
  logic              hsync_reg;
  logic              vsync_reg;
  logic              blank_reg;
  logic              line_sel_o_reg;
  logic [PIX_W-1:0]  rgb_reg;

  logic              in_edge;
  logic              lcnt_sat;
  logic              wr_en;
  logic [AW:0]       wr_addr;
  logic [AW-1:0]     rd_off;
  logic [AW:0]       rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  pix_sel;
  logic              at_wrap;
  logic [LPER_W:0]   oc_x;
  logic [LPER_W:0]   win_end;
  logic              in_win;
  sync_t             st0;

  // Rising hsync is detected on pix_ce samples only.
  assign in_edge  = vid.pix_ce_i & vid.hsync_i & ~hs_prev_reg;
  assign lcnt_sat = (lcnt_reg == LPER_SAT);
  // Pixels past the buffer depth are dropped; the edge cycle never writes.
  assign wr_en    = vid.pix_ce_i & ~vid.hblank_i & ~in_edge & (wcnt_reg != WCNT_FULL);
  assign wr_addr  = {wsel_reg, wcnt_reg[AW-1:0]};
  // Replays always read the bank that is not being written.
  assign rd_off   = out_cnt_reg[AW-1:0] - AW'(H_START);
  assign rd_addr  = {~wsel_reg, rd_off};
  assign at_wrap  = (out_cnt_reg == (half_reg - LPER_W'(1)));
  assign oc_x     = {1'b0, out_cnt_reg};
  assign win_end  = (LPER_W+1)'(H_START) + (LPER_W+1)'(rlen_reg);
  assign in_win   = (oc_x >= (LPER_W+1)'(H_START)) && (oc_x < win_end);

  // Stage-0 sync/blank decode from the output counter.
  always_comb begin
    st0          = SYNC_RST;
    st0.hsync    = (out_cnt_reg < LPER_W'(HSYNC_W));
    st0.vsync    = vs_line_reg;
    st0.blank    = ~(valid_reg & ~overrun_reg & in_win) | vb_line_reg;
    st0.line_sel = line_sel_reg;
  end

  // Capture side: write pointer, line-period measurement and per-line latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_prev_reg <= 1'b0;
      wsel_reg    <= 1'b0;
      wcnt_reg    <= '0;
      lcnt_reg    <= '0;
      half_reg    <= '0;
      rlen_reg    <= '0;
      vs_line_reg <= 1'b0;
      vb_line_reg <= 1'b0;
      seen_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      if (vid.pix_ce_i) hs_prev_reg <= vid.hsync_i;
      if (in_edge) begin
        wsel_reg    <= ~wsel_reg;
        rlen_reg    <= wcnt_reg;
        wcnt_reg    <= '0;
        lcnt_reg    <= LPER_W'(1);
        half_reg    <= lcnt_reg >> 1;
        vs_line_reg <= vid.vsync_i;
        vb_line_reg <= vid.vblank_i;
        // First edge after reset measures nothing useful; a saturated
        // period means the input sync was lost.
        valid_reg   <= seen_reg & ~lcnt_sat;
        seen_reg    <= 1'b1;
      end else begin
        if (!lcnt_sat) lcnt_reg <= lcnt_reg + LPER_W'(1);
        if (wr_en)     wcnt_reg <= wcnt_reg + (AW+1)'(1);
      end
    end
  end

  // Output line timing: two replays per input line, then blanked free-running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_cnt_reg  <= '0;
      line_sel_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (in_edge) begin
      out_cnt_reg  <= '0;
      line_sel_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (at_wrap) begin
      out_cnt_reg  <= '0;
      line_sel_reg <= 1'b1;
      if (line_sel_reg) overrun_reg <= 1'b1;
    end else begin
      out_cnt_reg  <= out_cnt_reg + LPER_W'(1);
    end
  end

  line_buffer_dp #(
    .DW (PIX_W),
    .AW (AW + 1)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (vid.rgb_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef SCANLINE_EN
  logic [PIX_W-1:0] dim_data;
  for (genvar gi = 0; gi < NCH; gi++) begin : g_dim
    assign dim_data[gi*CH_W +: CH_W] = rd_data[gi*CH_W +: CH_W] >> 1;
  end
  assign pix_sel = st1_reg.line_sel ? dim_data : rd_data;
`else
  assign pix_sel = rd_data;
`endif

  // Two-stage output pipeline keeps sync, blank and pixel aligned with the RAM read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st1_reg        <= SYNC_RST;
      hsync_reg      <= RST_HSYNC;
      vsync_reg      <= RST_VSYNC;
      blank_reg      <= RST_BLANK;
      line_sel_o_reg <= RST_LINE_SEL;
      rgb_reg        <= '0;
    end else begin
      st1_reg        <= st0;
      hsync_reg      <= st1_reg.hsync;
      vsync_reg      <= st1_reg.vsync;
      blank_reg      <= st1_reg.blank;
      line_sel_o_reg <= st1_reg.line_sel;
      rgb_reg        <= st1_reg.blank ? '0 : pix_sel;
    end
  end

  assign vid.hsync_o    = hsync_reg;
  assign vid.vsync_o    = vsync_reg;
  assign vid.blank_o    = blank_reg;
  assign vid.line_sel_o = line_sel_o_reg;
  assign vid.rgb_o      = rgb_reg;

endmodule
